// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcodes, decode FSM states, condition-code reset value.
// No latency (constants and a pure function only).
// No backpressure (no handshakes live here).
package lc3_pkg;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_RTI  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_RES  = 4'b1101;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam logic [2:0] NZP_RESET = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_MEM  = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXEC_WAIT = 3'd3,
      ST_DONE      = 3'd4
   } dec_state_t;

   // Opcodes that write a destination register and therefore update the condition codes.
   function automatic logic is_writing(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) ||
             (op == OP_LD)  || (op == OP_LDR) || (op == OP_LDI) ||
             (op == OP_LEA);
   endfunction

endpackage

// File: rtl/nzp_gen.sv
// Condition-code generator: 16-bit two's-complement value -> one-hot {n,z,p}.
// Combinational, zero latency.
// No backpressure (pure function of the input).
module nzp_gen (
   input  logic [15:0] value,
   output logic [2:0]  nzp
);

   // Exactly one of negative / zero / positive is set for any value.
   always_comb begin
      nzp[2] = value[15];
      nzp[1] = (value == 16'h0000);
      nzp[0] = !value[15] && (value != 16'h0000);
   end

endmodule

// File: rtl/decode.sv
// LC-3 decode stage: latches the fetched instruction, exposes its fields, tracks condition codes.
// IR captured MEM_LATENCY edges after decode_start; decode_done the cycle after capture.
// No queueing: decode_start is dropped outside IDLE; EXEC_WAIT stalls until result_valid.
module decode
   import lc3_pkg::*;
#(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        decode_start,
   input  logic [15:0] dout,
   input  logic [15:0] result_in,
   input  logic        result_valid,
   output logic [3:0]  opCode_out,
   output logic [8:0]  offset_out,
   output logic [2:0]  br_nzp,
   output logic [2:0]  result_nzp,
   output logic [2:0]  dr,
   output logic [2:0]  sr1,
   output logic [2:0]  sr2,
   output logic [4:0]  imm5,
   output logic        imm_mode,
   output logic        decode_done,
   output logic        fetch_start,
   output logic        illegal
);

   localparam logic [1:0] CNT_LOAD = 2'(MEM_LATENCY - 1);

   dec_state_t  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] ir_q, ir_d;
   logic [2:0]  nzp_q, nzp_d;
   logic [2:0]  nzp_new;

   nzp_gen u_nzp_gen (
      .value (result_in),
      .nzp   (nzp_new)
   );

   // State register plus IR, latency counter and condition codes; reset abandons any instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
         ir_q    <= 16'h0000;
         nzp_q   <= NZP_RESET;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ir_q    <= ir_d;
         nzp_q   <= nzp_d;
      end
   end

   // Next-state and datapath update: IR loads only on the last WAIT_MEM cycle, nzp only on a result.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ir_d    = ir_q;
      nzp_d   = nzp_q;
      case (state_q)
         ST_IDLE: begin
            if (decode_start) begin
               state_d = ST_WAIT_MEM;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_WAIT_MEM: begin
            if (cnt_q == 2'd0) begin
               ir_d    = dout;
               state_d = ST_DECODE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_DECODE: begin
            state_d = is_writing(ir_q[15:12]) ? ST_EXEC_WAIT : ST_DONE;
         end
         ST_EXEC_WAIT: begin
            if (result_valid) begin
               nzp_d   = nzp_new;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs: strobes decoded from state, instruction fields straight from IR.
   always_comb begin
      decode_done = (state_q == ST_DECODE);
      illegal     = (state_q == ST_DECODE) && (ir_q[15:12] == OP_RES);
      fetch_start = (state_q == ST_DONE);
      opCode_out  = ir_q[15:12];
      br_nzp      = ir_q[11:9];
      offset_out  = ir_q[8:0];
      dr          = ir_q[11:9];
      sr1         = ir_q[8:6];
      sr2         = ir_q[2:0];
      imm_mode    = ir_q[5];
      imm5        = ir_q[4:0];
      result_nzp  = nzp_q;
   end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Every step is a fixed number of clocks, so the run always terminates.
module tb_decode;
   import lc3_pkg::*;

   logic        clk = 1'b0;
   logic        rst1_n, rst3_n, ds1, ds3;
   logic [15:0] dout, result_in;
   logic        result_valid;

   logic [3:0] op1, op3;
   logic [8:0] off1, off3;
   logic [2:0] brn1, brn3, nzp1, nzp3, dr1, dr3, sr1_1, sr1_3, sr2_1, sr2_3;
   logic [4:0] imm1, imm3;
   logic       im1, im3, done1, done3, fs1, fs3, ill1, ill3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   decode #(.MEM_LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst1_n), .decode_start(ds1), .dout(dout),
      .result_in(result_in), .result_valid(result_valid),
      .opCode_out(op1), .offset_out(off1), .br_nzp(brn1), .result_nzp(nzp1),
      .dr(dr1), .sr1(sr1_1), .sr2(sr2_1), .imm5(imm1), .imm_mode(im1),
      .decode_done(done1), .fetch_start(fs1), .illegal(ill1)
   );

   decode #(.MEM_LATENCY(3)) u3 (
      .clk(clk), .rst_n(rst3_n), .decode_start(ds3), .dout(dout),
      .result_in(result_in), .result_valid(result_valid),
      .opCode_out(op3), .offset_out(off3), .br_nzp(brn3), .result_nzp(nzp3),
      .dr(dr3), .sr1(sr1_3), .sr2(sr2_3), .imm5(imm3), .imm_mode(im3),
      .decode_done(done3), .fetch_start(fs3), .illegal(ill3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst1_n = 1'b0; rst3_n = 1'b0; ds1 = 1'b0; ds3 = 1'b0;
      dout = 16'h0000; result_in = 16'h0000; result_valid = 1'b0;

      // ---- reset held 5 cycles ----
      repeat (5) tick();
      chk("rst_held_nzp", 16'(nzp1), 16'h2);
      rst1_n = 1'b1; rst3_n = 1'b1;
      tick();
      chk("rst_ir", {op1, brn1, off1}, 16'h0000);
      chk("rst_nzp", 16'(nzp1), 16'h2);
      chk("rst_strobes", {13'h0, done1, fs1, ill1}, 16'h0);
      chk("rst_state", 16'(u1.state_q), 16'(ST_IDLE));

      // ---- ADD 16'h12A3, ML=1 ----
      ds1 = 1'b1; dout = 16'h12A3;
      tick();
      ds1 = 1'b0;
      chk("add_wait_done", 16'(done1), 16'h0);
      tick();
      dout = 16'h0000;
      chk("add_done", 16'(done1), 16'h1);
      chk("add_op", 16'(op1), 16'h1);
      chk("add_dr", 16'(dr1), 16'h1);
      chk("add_sr1", 16'(sr1_1), 16'h2);
      chk("add_sr2", 16'(sr2_1), 16'h3);
      chk("add_imm_mode", 16'(im1), 16'h1);
      chk("add_imm5", 16'(imm1), 16'h3);
      chk("add_illegal", 16'(ill1), 16'h0);
      chk("add_fs_early", 16'(fs1), 16'h0);
      tick();
      chk("add_exec_done", 16'(done1), 16'h0);
      chk("add_exec_fs", 16'(fs1), 16'h0);
      tick();
      chk("add_exec_hold", 16'(u1.state_q), 16'(ST_EXEC_WAIT));
      chk("add_exec_hold_fs", 16'(fs1), 16'h0);
      result_valid = 1'b1; result_in = 16'hFFFE;
      tick();
      result_valid = 1'b0;
      chk("add_nzp", 16'(nzp1), 16'h4);
      chk("add_fs", 16'(fs1), 16'h1);
      tick();
      chk("add_fs_pulse", 16'(fs1), 16'h0);
      chk("add_dr_stable", 16'(dr1), 16'h1);

      // ---- BR 16'h0405 ----
      ds1 = 1'b1; dout = 16'h0405;
      tick();
      ds1 = 1'b0;
      tick();
      chk("br_done", 16'(done1), 16'h1);
      chk("br_nzp_field", 16'(brn1), 16'h2);
      chk("br_offset", 16'(off1), 16'h005);
      chk("br_fs_early", 16'(fs1), 16'h0);
      tick();
      chk("br_fs", 16'(fs1), 16'h1);
      chk("br_nzp_kept", 16'(nzp1), 16'h4);
      tick();
      chk("br_idle", 16'(u1.state_q), 16'(ST_IDLE));

      // ---- AND 16'h5020, result_valid in DECODE ignored ----
      ds1 = 1'b1; dout = 16'h5020;
      tick();
      ds1 = 1'b0;
      tick();
      chk("and_done", 16'(done1), 16'h1);
      result_valid = 1'b1; result_in = 16'h0000;
      tick();
      result_valid = 1'b0;
      chk("and_ignore_state", 16'(u1.state_q), 16'(ST_EXEC_WAIT));
      chk("and_ignore_nzp", 16'(nzp1), 16'h4);
      chk("and_ignore_fs", 16'(fs1), 16'h0);
      tick();
      result_valid = 1'b1;
      tick();
      result_valid = 1'b0;
      chk("and_nzp", 16'(nzp1), 16'h2);
      chk("and_fs", 16'(fs1), 16'h1);
      tick();

      // ---- reserved 16'hD000 ----
      ds1 = 1'b1; dout = 16'hD000;
      tick();
      ds1 = 1'b0;
      tick();
      chk("res_done", 16'(done1), 16'h1);
      chk("res_illegal", 16'(ill1), 16'h1);
      tick();
      chk("res_fs", 16'(fs1), 16'h1);
      chk("res_ill_pulse", 16'(ill1), 16'h0);
      chk("res_nzp_kept", 16'(nzp1), 16'h2);
      tick();

      // ---- ML=3: ADD with a second start ignored, positive result ----
      ds3 = 1'b1; dout = 16'h1021;
      tick();
      ds3 = 1'b0;
      tick();
      ds3 = 1'b1;
      tick();
      ds3 = 1'b0;
      chk("ml3_wait_done", 16'(done3), 16'h0);
      tick();
      chk("ml3_done", 16'(done3), 16'h1);
      chk("ml3_op", 16'(op3), 16'h1);
      tick();
      result_valid = 1'b1; result_in = 16'h0005;
      tick();
      result_valid = 1'b0;
      chk("ml3_nzp_pos", 16'(nzp3), 16'h1);
      chk("ml3_fs", 16'(fs3), 16'h1);
      tick();
      tick();
      chk("ml3_no_queue", 16'(u3.state_q), 16'(ST_IDLE));

      // ---- ML=3: reset during EXEC_WAIT ----
      ds3 = 1'b1;
      tick();
      ds3 = 1'b0;
      repeat (3) tick();
      chk("ml3b_done", 16'(done3), 16'h1);
      tick();
      chk("ml3b_exec", 16'(u3.state_q), 16'(ST_EXEC_WAIT));
      #2 rst3_n = 1'b0;
      #1;
      chk("ml3b_async_nzp", 16'(nzp3), 16'h2);
      chk("ml3b_async_state", 16'(u3.state_q), 16'(ST_IDLE));
      chk("ml3b_async_ir", {op3, brn3, off3}, 16'h0000);
      tick();
      rst3_n = 1'b1;
      result_valid = 1'b1; result_in = 16'hFFFF;
      tick();
      result_valid = 1'b0;
      chk("ml3b_fs0", 16'(fs3), 16'h0);
      chk("ml3b_nzp_kept", 16'(nzp3), 16'h2);
      tick();
      chk("ml3b_fs1", 16'(fs3), 16'h0);
      tick();
      chk("ml3b_fs2", 16'(fs3), 16'h0);
      chk("ml3b_idle", 16'(u3.state_q), 16'(ST_IDLE));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
